// File: rtl/h264intra_cc_sequencer.sv
// Chroma-block sequencer: loads one channel, computes all its blocks, then emits
// each block's output burst and waits for reconstruction feedback before moving on.
module h264intra_cc_sequencer #(
  parameter int NCH      = 2,
  parameter int NBLK     = 4,
  parameter int LOADW    = 16,
  parameter int CALC_CYC = 4,
  parameter int OUT_CYC  = 6,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int BW      = (NBLK > 1) ? $clog2(NBLK) : 1,
  localparam int WW      = $clog2(LOADW),
  localparam int MAXC    = (CALC_CYC > OUT_CYC) ? CALC_CYC : OUT_CYC,
  localparam int YW      = (MAXC > 1) ? $clog2(MAXC) : 1
) (
  input  logic          CLK2,
  input  logic          NEWLINE,
  input  logic          STROBEI,
  input  logic          READYO,
  input  logic          FBSTROBE,
  output logic [CW-1:0] ch,
  output logic [BW-1:0] blk,
  output logic [WW-1:0] wcnt,
  output logic [YW-1:0] cyc,
  output logic          load_en,
  output logic          calc_en,
  output logic          out_en,
  output logic          fb_wait,
  output logic          blk_done,
  output logic          mb_done,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CALC, S_WAITO, S_OUT, S_FBWAIT, S_DONE
  } state_t;

  localparam logic [CW-1:0] C_LAST  = CW'(NCH - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(NBLK - 1);
  localparam logic [WW-1:0] W_LAST  = WW'(LOADW - 1);
  localparam logic [YW-1:0] CC_LAST = YW'(CALC_CYC - 1);
  localparam logic [YW-1:0] OC_LAST = YW'(OUT_CYC - 1);

  state_t        r_state, w_state;
  logic [CW-1:0] r_ch, w_ch;
  logic [BW-1:0] r_blk, w_blk;
  logic [WW-1:0] r_wcnt, w_wcnt;
  logic [YW-1:0] r_cyc, w_cyc;
  logic          r_fb_seen, w_fb_seen;
  logic          r_err, w_err;
  logic          w_loading;
  logic          w_fb_exit;

  assign w_loading = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_fb_exit = (r_state == S_FBWAIT) && (FBSTROBE || r_fb_seen);

  always_ff @(posedge CLK2) begin
    if (NEWLINE) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_blk     <= '0;
      r_wcnt    <= '0;
      r_cyc     <= '0;
      r_fb_seen <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ch      <= w_ch;
      r_blk     <= w_blk;
      r_wcnt    <= w_wcnt;
      r_cyc     <= w_cyc;
      r_fb_seen <= w_fb_seen;
      r_err     <= w_err;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_ch      = r_ch;
    w_blk     = r_blk;
    w_wcnt    = r_wcnt;
    w_cyc     = r_cyc;
    w_fb_seen = r_fb_seen;
    w_err     = r_err || (STROBEI && !w_loading);
    case (r_state)
      S_IDLE: begin
        if (STROBEI) begin
          w_wcnt  = WW'(1);
          w_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (STROBEI) begin
          if (r_wcnt == W_LAST) begin
            w_wcnt  = '0;
            w_blk   = '0;
            w_cyc   = '0;
            w_state = S_CALC;
          end else begin
            w_wcnt = r_wcnt + 1'b1;
          end
        end
      end
      S_CALC: begin
        if (r_cyc == CC_LAST) begin
          w_cyc = '0;
          if (r_blk == B_LAST) begin
            w_blk   = '0;
            w_state = S_WAITO;
          end else begin
            w_blk = r_blk + 1'b1;
          end
        end else begin
          w_cyc = r_cyc + 1'b1;
        end
      end
      S_WAITO: begin
        if (READYO) w_state = S_OUT;
      end
      S_OUT: begin
        // Feedback arriving mid-burst is latched so FBWAIT can leave on its first cycle.
        if (FBSTROBE) w_fb_seen = 1'b1;
        if (r_cyc == OC_LAST) begin
          w_cyc   = '0;
          w_state = S_FBWAIT;
        end else begin
          w_cyc = r_cyc + 1'b1;
        end
      end
      S_FBWAIT: begin
        if (w_fb_exit) begin
          w_fb_seen = 1'b0;
          if (r_blk != B_LAST) begin
            w_blk   = r_blk + 1'b1;
            w_state = S_WAITO;
          end else if (r_ch != C_LAST) begin
            w_ch    = r_ch + 1'b1;
            w_blk   = '0;
            w_state = S_LOAD;
          end else begin
            w_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_ch    = '0;
        w_blk   = '0;
        w_wcnt  = '0;
        w_cyc   = '0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign ch       = r_ch;
  assign blk      = r_blk;
  assign wcnt     = r_wcnt;
  assign cyc      = r_cyc;
  assign load_en  = STROBEI && w_loading;
  assign calc_en  = (r_state == S_CALC);
  assign out_en   = (r_state == S_OUT);
  assign fb_wait  = (r_state == S_FBWAIT);
  assign blk_done = w_fb_exit;
  assign mb_done  = (r_state == S_DONE);
  assign busy     = (r_state != S_IDLE);
  assign err      = r_err;

endmodule

// File: tb/tb_h264intra_cc_sequencer.sv
// Directed bench for h264intra_cc_sequencer: default configuration plus a
// small NCH=3/NBLK=1/LOADW=4 configuration, all expectations hand-derived.
module tb_h264intra_cc_sequencer;

  logic CLK2 = 1'b0;
  always #5 CLK2 = ~CLK2;

  logic       NEWLINE, STROBEI, READYO, FBSTROBE;
  logic [0:0] ch;
  logic [1:0] blk;
  logic [3:0] wcnt;
  logic [2:0] cyc;
  logic       load_en, calc_en, out_en, fb_wait, blk_done, mb_done, busy, err;

  logic       s_NEWLINE, s_STROBEI, s_READYO, s_FBSTROBE;
  logic [1:0] s_ch;
  logic [0:0] s_blk;
  logic [1:0] s_wcnt;
  logic [0:0] s_cyc;
  logic       s_load_en, s_calc_en, s_out_en, s_fb_wait, s_blk_done, s_mb_done, s_busy, s_err;

  h264intra_cc_sequencer u_dut (
    .CLK2(CLK2), .NEWLINE(NEWLINE), .STROBEI(STROBEI), .READYO(READYO), .FBSTROBE(FBSTROBE),
    .ch(ch), .blk(blk), .wcnt(wcnt), .cyc(cyc), .load_en(load_en), .calc_en(calc_en),
    .out_en(out_en), .fb_wait(fb_wait), .blk_done(blk_done), .mb_done(mb_done),
    .busy(busy), .err(err)
  );

  h264intra_cc_sequencer #(
    .NCH(3), .NBLK(1), .LOADW(4), .CALC_CYC(1), .OUT_CYC(1)
  ) u_dut_small (
    .CLK2(CLK2), .NEWLINE(s_NEWLINE), .STROBEI(s_STROBEI), .READYO(s_READYO), .FBSTROBE(s_FBSTROBE),
    .ch(s_ch), .blk(s_blk), .wcnt(s_wcnt), .cyc(s_cyc), .load_en(s_load_en), .calc_en(s_calc_en),
    .out_en(s_out_en), .fb_wait(s_fb_wait), .blk_done(s_blk_done), .mb_done(s_mb_done),
    .busy(s_busy), .err(s_err)
  );

  int n_chk = 0;
  int n_err = 0;
  bit exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge CLK2);
    #2;
  endtask

  task automatic block_loop(input int c, input int b, input int rdl, input int fbb,
                            input bit abort, output bit ab);
    ab = 1'b0;
    check("wo_busy", 32'(busy), 1);
    check("wo_ch", 32'(ch), c);
    check("wo_blk", 32'(blk), b);
    check("wo_fb", 32'(fb_wait), 0);
    for (int k = 0; k < rdl; k++) begin
      READYO = 1'b0;
      check("wo_hold_out", 32'(out_en), 0);
      check("wo_hold_busy", 32'(busy), 1);
      step;
    end
    READYO = 1'b1;
    check("wo_out", 32'(out_en), 0);
    check("wo_calc", 32'(calc_en), 0);
    step;
    for (int k = 0; k < 6; k++) begin
      check("out_en", 32'(out_en), 1);
      check("out_cyc", 32'(cyc), k);
      check("out_blk", 32'(blk), b);
      if (abort && k == 2) begin
        NEWLINE = 1'b1;
        step;
        NEWLINE = 1'b0;
        exp_err = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_out", 32'(out_en), 0);
        check("rst_calc", 32'(calc_en), 0);
        check("rst_fb", 32'(fb_wait), 0);
        check("rst_blk_done", 32'(blk_done), 0);
        check("rst_load_en", 32'(load_en), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cnt", {ch, blk, wcnt, cyc}, 0);
        for (int j = 0; j < 3; j++) begin
          check("rst_mb_done", 32'(mb_done), 0);
          step;
        end
        ab = 1'b1;
        return;
      end
      FBSTROBE = (k == fbb);
      step;
      FBSTROBE = 1'b0;
    end
    check("fb_wait", 32'(fb_wait), 1);
    check("fb_out", 32'(out_en), 0);
    check("fb_cyc", 32'(cyc), 0);
    if (fbb >= 0) begin
      #1;
      check("blk_done_early", 32'(blk_done), 1);
      step;
    end else begin
      #1;
      check("blk_done_pre", 32'(blk_done), 0);
      step;
      check("fb_wait2", 32'(fb_wait), 1);
      FBSTROBE = 1'b1;
      #1;
      check("blk_done", 32'(blk_done), 1);
      step;
      FBSTROBE = 1'b0;
    end
    #1;
    check("fb_exit", 32'(fb_wait), 0);
    check("blk_done_clr", 32'(blk_done), 0);
  endtask

  task automatic run_mb(input int rd_blk, input int rd_delay, input int fb_blk,
                        input bit inj_err, input int ab_ch, input int ab_blk);
    bit ab;
    check("idle_busy", 32'(busy), 0);
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 16; i++) begin
        STROBEI = 1'b1;
        #1;
        check("load_en", 32'(load_en), 1);
        check("load_wcnt", 32'(wcnt), i);
        check("load_ch", 32'(ch), c);
        step;
      end
      STROBEI = 1'b0;
      for (int k = 0; k < 16; k++) begin
        check("calc_en", 32'(calc_en), 1);
        check("calc_blk", 32'(blk), k / 4);
        check("calc_cyc", 32'(cyc), k % 4);
        check("calc_wcnt", 32'(wcnt), 0);
        check("calc_err", 32'(err), 32'(exp_err));
        if (inj_err && c == 0 && k == 5) begin
          STROBEI = 1'b1;
          #1;
          check("calc_load_en", 32'(load_en), 0);
        end
        step;
        STROBEI = 1'b0;
        if (inj_err && c == 0 && k == 5) exp_err = 1'b1;
      end
      check("calc_end", 32'(calc_en), 0);
      for (int b = 0; b < 4; b++) begin
        block_loop(c, b, (b == rd_blk) ? rd_delay : 0, (b == fb_blk) ? 2 : -1,
                   (c == ab_ch && b == ab_blk), ab);
        if (ab) return;
      end
    end
    check("mb_done", 32'(mb_done), 1);
    check("done_err", 32'(err), 32'(exp_err));
    check("done_busy", 32'(busy), 1);
    step;
    check("post_mb_done", 32'(mb_done), 0);
    check("post_busy", 32'(busy), 0);
    check("post_cnt", {ch, blk, wcnt, cyc}, 0);
    check("post_err", 32'(err), 32'(exp_err));
  endtask

  task automatic run_small;
    check("s_idle", 32'(s_busy), 0);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 4; i++) begin
        s_STROBEI = 1'b1;
        #1;
        check("s_load_en", 32'(s_load_en), 1);
        check("s_wcnt", 32'(s_wcnt), i);
        check("s_load_ch", 32'(s_ch), c);
        step;
      end
      s_STROBEI = 1'b0;
      check("s_calc", 32'(s_calc_en), 1);
      check("s_calc_cnt", {s_blk, s_cyc}, 0);
      step;
      check("s_waito", {s_busy, s_calc_en, s_out_en, s_fb_wait}, 32'b1000);
      step;
      check("s_out", 32'(s_out_en), 1);
      step;
      check("s_fb_wait", 32'(s_fb_wait), 1);
      s_FBSTROBE = 1'b1;
      #1;
      check("s_blk_done", 32'(s_blk_done), 1);
      check("s_blk", 32'(s_blk), 0);
      step;
      s_FBSTROBE = 1'b0;
    end
    check("s_mb_done", 32'(s_mb_done), 1);
    check("s_done_ch", 32'(s_ch), 2);
    check("s_err", 32'(s_err), 0);
    step;
    check("s_post_busy", 32'(s_busy), 0);
    check("s_post_mb_done", 32'(s_mb_done), 0);
    check("s_post_ch", 32'(s_ch), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    NEWLINE = 1'b1; STROBEI = 1'b0; READYO = 1'b1; FBSTROBE = 1'b0;
    s_NEWLINE = 1'b1; s_STROBEI = 1'b0; s_READYO = 1'b1; s_FBSTROBE = 1'b0;
    step;
    step;
    NEWLINE = 1'b0;
    s_NEWLINE = 1'b0;
    #1;
    check("reset_flags", {load_en, calc_en, out_en, fb_wait, blk_done, mb_done, busy, err}, 0);
    check("reset_cnt", {ch, blk, wcnt, cyc}, 0);
    run_mb(-1, 0, -1, 1'b0, -1, -1);
    run_mb(2, 10, 1, 1'b1, -1, -1);
    run_mb(-1, 0, -1, 1'b0, 1, 1);
    run_mb(-1, 0, -1, 1'b0, -1, -1);
    run_small();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
